// File: rtl/issue_queue_if.sv
// Bundles the fetch-side, unit-status and issue-side signals of the
// instruction queue so that one port carries the whole datapath.
interface issue_queue_if;
  logic        IF_ins_sgn;
  logic [31:0] IF_ins;
  logic        IF_jump_flag;
  logic [31:0] IF_jump_pc;
  logic        IF_full;
  logic        ROB_full;
  logic        RS_full;
  logic        LSB_full;
  logic        ROB_clear;
  logic        ISS_sgn;
  logic [31:0] ISS_ins;
  logic        ISS_jump_flag;
  logic [31:0] ISS_jump_pc;
  logic [31:0] stall_cnt;

  modport master (
    output IF_ins_sgn, IF_ins, IF_jump_flag, IF_jump_pc,
    output ROB_full, RS_full, LSB_full, ROB_clear,
    input  IF_full, ISS_sgn, ISS_ins, ISS_jump_flag, ISS_jump_pc, stall_cnt
  );

  modport slave (
    input  IF_ins_sgn, IF_ins, IF_jump_flag, IF_jump_pc,
    input  ROB_full, RS_full, LSB_full, ROB_clear,
    output IF_full, ISS_sgn, ISS_ins, ISS_jump_flag, ISS_jump_pc, stall_cnt
  );
endinterface

// File: rtl/issue_queue_ctrl.sv
// In-order instruction FIFO between fetch and issue: dispatches the head only
// when every unit the instruction class needs has room; flushes on rollback.
module issue_queue_ctrl #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  issue_queue_if.slave bus
);

  typedef enum logic [1:0] {
    CLS_ALU,
    CLS_MEM,
    CLS_ROBONLY
  } ins_class_e;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [31:0]       r_ins_mem  [DEPTH];
  logic              r_flag_mem [DEPTH];
  logic [31:0]       r_pc_mem   [DEPTH];
  logic [ADDR_W-1:0] r_head;
  logic [ADDR_W-1:0] r_tail;
  logic [ADDR_W:0]   r_count;
  logic              r_iss_sgn;
  logic [31:0]       r_iss_ins;
  logic              r_iss_flag;
  logic [31:0]       r_iss_pc;
  logic [31:0]       r_stall_cnt;

  logic [6:0]  w_opcode;
  ins_class_e  w_class;
  logic        w_class_ok;
  logic        w_not_empty;
  logic        w_push;
  logic        w_pop;

  // NOTE: every signal gets a default before the case, so no path can leave it unassigned and infer a latch.
  always_comb begin
    w_opcode = r_ins_mem[r_head][6:0];
    w_class  = CLS_ALU;
    case (w_opcode)
      7'b0000011, 7'b0100011:             w_class = CLS_MEM;
      7'b0110111, 7'b0010111, 7'b1101111: w_class = CLS_ROBONLY;
      default:                            w_class = CLS_ALU;
    endcase

    w_class_ok = 1'b0;
    case (w_class)
      CLS_MEM:     w_class_ok = !bus.ROB_full && !bus.RS_full && !bus.LSB_full;
      CLS_ROBONLY: w_class_ok = !bus.ROB_full;
      default:     w_class_ok = !bus.ROB_full && !bus.RS_full;
    endcase

    w_not_empty = (r_count != '0);
    w_push      = bus.IF_ins_sgn && (r_count != FULL_CNT);
    w_pop       = w_not_empty && w_class_ok;
  end

  // NOTE: the entry storage has no reset; head/tail/count alone decide which slots are meaningful.
  always_ff @(posedge clk) begin
    if (!rst && rdy && !bus.ROB_clear && w_push) begin
      r_ins_mem[r_tail]  <= bus.IF_ins;
      r_flag_mem[r_tail] <= bus.IF_jump_flag;
      r_pc_mem[r_tail]   <= bus.IF_jump_pc;
    end
  end

  // NOTE: state registers use non-blocking assignments so every process sees the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_iss_sgn   <= 1'b0;
      r_iss_ins   <= '0;
      r_iss_flag  <= 1'b0;
      r_iss_pc    <= '0;
      r_stall_cnt <= '0;
    end else if (!rdy) begin
      // The strobe must not repeat while frozen; everything else holds.
      r_iss_sgn <= 1'b0;
    end else if (bus.ROB_clear) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_iss_sgn <= 1'b0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + ADDR_W'(1);
      end

      r_iss_sgn <= w_pop;
      if (w_pop) begin
        r_iss_ins  <= r_ins_mem[r_head];
        r_iss_flag <= r_flag_mem[r_head];
        r_iss_pc   <= r_pc_mem[r_head];
        r_head     <= r_head + ADDR_W'(1);
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
        default: r_count <= r_count;
      endcase

      if (w_not_empty && !w_class_ok && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign bus.IF_full       = (r_count == FULL_CNT);
  assign bus.ISS_sgn       = r_iss_sgn;
  assign bus.ISS_ins       = r_iss_ins;
  assign bus.ISS_jump_flag = r_iss_flag;
  assign bus.ISS_jump_pc   = r_iss_pc;
  assign bus.stall_cnt     = r_stall_cnt;

endmodule
